// File: rtl/mcpu_dram_arbiter_pkg.sv
// rtl/mcpu_dram_arbiter_pkg.sv - shared types and width defaults for the MCPU DRAM arbiter
package mcpu_dram_arbiter_pkg;

    localparam int DRAM_DATA_BITS_DEF = 16;
    localparam int DRAM_ADDR_BITS_DEF = 14;

    typedef enum logic [1:0] {
        MCPU_ARB_IDLE   = 2'd0,
        MCPU_ARB_ACCESS = 2'd1,
        MCPU_ARB_DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mcpu_dram_arbiter_rr_arb2.sv
// rtl/mcpu_dram_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module mcpu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // A lone requester always wins; under contention the port that did not win last time goes.
    always_comb begin
        grant_valid = |req;
        grant_id    = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/mcpu_dram_arbiter.sv
// rtl/mcpu_dram_arbiter.sv - serialises CPU and DMA requests onto one single-port DRAM
module mcpu_dram_arbiter
    import mcpu_dram_arbiter_pkg::*;
#(
    parameter int DRAM_DATA_BITS = DRAM_DATA_BITS_DEF,
    parameter int DRAM_ADDR_BITS = DRAM_ADDR_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      p0_req,
    input  logic                      p0_we,
    input  logic [DRAM_ADDR_BITS-1:0] p0_addr,
    input  logic [DRAM_DATA_BITS-1:0] p0_wdata,
    output logic                      p0_ack,
    output logic [DRAM_DATA_BITS-1:0] p0_rdata,
    input  logic                      p1_req,
    input  logic                      p1_we,
    input  logic [DRAM_ADDR_BITS-1:0] p1_addr,
    input  logic [DRAM_DATA_BITS-1:0] p1_wdata,
    output logic                      p1_ack,
    output logic [DRAM_DATA_BITS-1:0] p1_rdata,
    output logic [DRAM_ADDR_BITS-1:0] dram_addr,
    output logic [DRAM_DATA_BITS-1:0] dram_data_in,
    input  logic [DRAM_DATA_BITS-1:0] dram_data_out,
    output logic                      dram_write_ena
);

    arb_state_e                state_q, state_d;
    logic                      lat_we_q;
    logic [DRAM_ADDR_BITS-1:0] lat_addr_q;
    logic [DRAM_DATA_BITS-1:0] lat_wdata_q;
    logic                      lat_id_q;
    logic                      last_grant_q;
    logic [DRAM_DATA_BITS-1:0] p0_rdata_q, p1_rdata_q;
    logic                      grant_valid, grant_id;
    logic                      load_d;

    mcpu_rr_arb2 u_rr_arb2 (
        .req         ({p1_req, p0_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // The latched address/data drive the DRAM directly, so they hold their value outside ACCESS.
    assign dram_addr    = lat_addr_q;
    assign dram_data_in = lat_wdata_q;
    assign p0_rdata     = p0_rdata_q;
    assign p1_rdata     = p1_rdata_q;

    // Next state, acks and write strobe; reset gates the strobe so an in-flight write never commits.
    always_comb begin
        state_d        = state_q;
        load_d         = 1'b0;
        p0_ack         = 1'b0;
        p1_ack         = 1'b0;
        dram_write_ena = 1'b0;
        case (state_q)
            MCPU_ARB_IDLE: begin
                if (grant_valid) begin
                    load_d  = 1'b1;
                    state_d = MCPU_ARB_ACCESS;
                end
            end
            MCPU_ARB_ACCESS: begin
                dram_write_ena = lat_we_q & ~reset;
                state_d        = MCPU_ARB_DONE;
            end
            MCPU_ARB_DONE: begin
                p0_ack  = ~lat_id_q;
                p1_ack  = lat_id_q;
                state_d = MCPU_ARB_IDLE;
            end
            default: state_d = MCPU_ARB_IDLE;
        endcase
    end

    // State register, winner latch, read-data capture and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MCPU_ARB_IDLE;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_d) begin
                lat_id_q    <= grant_id;
                lat_we_q    <= grant_id ? p1_we    : p0_we;
                lat_addr_q  <= grant_id ? p1_addr  : p0_addr;
                lat_wdata_q <= grant_id ? p1_wdata : p0_wdata;
            end
            if (state_q == MCPU_ARB_ACCESS && !lat_we_q) begin
                if (lat_id_q) p1_rdata_q <= dram_data_out;
                else          p0_rdata_q <= dram_data_out;
            end
            if (state_q == MCPU_ARB_DONE) begin
                last_grant_q <= lat_id_q;
            end
        end
    end

endmodule

// File: tb/tb_mcpu_dram_arbiter.sv
// tb/tb_mcpu_dram_arbiter.sv - scoreboard and vector-table bench for mcpu_dram_arbiter
module tb_mcpu_dram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [13:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [13:0] dram_addr;
    logic [15:0] dram_data_in, dram_data_out;
    logic        dram_write_ena;

    logic [15:0] mem [0:16383];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        bit          port;
        logic [15:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit          port;
        bit          we;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[9];

    logic [15:0] exp_rd [2];

    mcpu_dram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_ack         (p0_ack),
        .p0_rdata       (p0_rdata),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_ack         (p1_ack),
        .p1_rdata       (p1_rdata),
        .dram_addr      (dram_addr),
        .dram_data_in   (dram_data_in),
        .dram_data_out  (dram_data_out),
        .dram_write_ena (dram_write_ena)
    );

    always #5 clk = ~clk;

    // DRAM model: asynchronous read, write on posedge.
    assign dram_data_out = mem[dram_addr];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (dram_write_ena) begin
            mem[dram_addr] = dram_data_in;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation.
    always @(negedge clk) begin : mon
        sb_t e;
        if (!reset && (p0_ack || p1_ack)) begin
            if (p0_ack && p1_ack) begin
                n_tests++; n_fail++;
                $display("FAIL dual_ack: both acks high at cycle %0d", cyc);
            end else if (sbq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_ack: p0_ack=%b p1_ack=%b at cycle %0d", p0_ack, p1_ack, cyc);
            end else begin
                e = sbq.pop_front();
                chk("ack_port", {31'd0, p1_ack}, {31'd0, e.port});
                chk("ack_rdata", {16'd0, (e.port ? p1_rdata : p0_rdata)}, {16'd0, e.rdata});
            end
        end
    end

    task automatic wait_ack(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((which != 1 && p0_ack) || (which != 0 && p1_ack)) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL ack_timeout: no ack for selector %0d within 20 cycles", which);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [13:0] addr,
                         input logic [15:0] wd);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end
    endtask

    task automatic expect_ack(input bit port, input bit we, input logic [15:0] exp);
        sb_t e;
        if (!we) exp_rd[port] = exp;
        e.port  = port;
        e.rdata = exp_rd[port];
        sbq.push_back(e);
    endtask

    task automatic access(input bit port, input bit we, input logic [13:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp);
        int t0, w0;
        bit ok;
        @(negedge clk);
        t0 = cyc;
        w0 = wr_cnt;
        drive(port, 1'b1, we, addr, wd);
        expect_ack(port, we, exp);
        wait_ack(port ? 1 : 0, ok);
        drive(port, 1'b0, 1'b0, '0, '0);
        if (ok) chk("latency", cyc - t0, 2);
        chk("write_strobes", wr_cnt - w0, {31'd0, we});
        chk("other_rdata", {16'd0, (port ? p0_rdata : p1_rdata)}, {16'd0, exp_rd[!port]});
    endtask

    initial begin
        int  t0, tp;
        bit  ok;
        for (int i = 0; i < 16384; i++) mem[i] = 16'hC3A5 ^ 16'(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        vecs[0] = '{port: 1'b0, we: 1'b1, addr: 14'h0010, wdata: 16'hBEEF, exp: 16'h0000};
        vecs[1] = '{port: 1'b0, we: 1'b0, addr: 14'h0010, wdata: 16'h0000, exp: 16'hBEEF};
        vecs[2] = '{port: 1'b1, we: 1'b1, addr: 14'h3FFF, wdata: 16'hA5C3, exp: 16'h0000};
        vecs[3] = '{port: 1'b0, we: 1'b0, addr: 14'h3FFF, wdata: 16'h0000, exp: 16'hA5C3};
        vecs[4] = '{port: 1'b1, we: 1'b0, addr: 14'h0010, wdata: 16'h0000, exp: 16'hBEEF};
        vecs[5] = '{port: 1'b0, we: 1'b1, addr: 14'h0000, wdata: 16'h5A5A, exp: 16'h0000};
        vecs[6] = '{port: 1'b1, we: 1'b1, addr: 14'h0001, wdata: 16'hFFFF, exp: 16'h0000};
        vecs[7] = '{port: 1'b1, we: 1'b0, addr: 14'h0001, wdata: 16'h0000, exp: 16'hFFFF};
        vecs[8] = '{port: 1'b0, we: 1'b0, addr: 14'h0001, wdata: 16'h0000, exp: 16'hFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_p0_ack", {31'd0, p0_ack}, 0);
        chk("rst_p1_ack", {31'd0, p1_ack}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("rst_dram_addr", {18'd0, dram_addr}, 0);
        chk("rst_dram_data_in", {16'd0, dram_data_in}, 0);
        chk("rst_write_ena", {31'd0, dram_write_ena}, 0);
        reset = 1'b0;

        // Simultaneous reads right after reset: p0 first, p1 three cycles later
        @(negedge clk);
        t0 = cyc;
        drive(0, 1'b1, 1'b0, 14'h0005, '0);
        drive(1, 1'b1, 1'b0, 14'h0006, '0);
        expect_ack(0, 1'b0, 16'hC3A0);
        expect_ack(1, 1'b0, 16'hC3A3);
        wait_ack(0, ok);
        drive(0, 1'b0, 1'b0, '0, '0);
        if (ok) chk("both_p0_latency", cyc - t0, 2);
        tp = cyc;
        wait_ack(1, ok);
        drive(1, 1'b0, 1'b0, '0, '0);
        if (ok) chk("both_p1_spacing", cyc - tp, 3);

        // Continuous contention: strict alternation, one access per 3 cycles
        @(negedge clk);
        t0 = cyc;
        drive(0, 1'b1, 1'b0, 14'h0007, '0);
        drive(1, 1'b1, 1'b0, 14'h0008, '0);
        for (int k = 0; k < 6; k++) expect_ack(k[0], 1'b0, k[0] ? 16'hC3AD : 16'hC3A2);
        tp = t0 - 1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(2, ok);
            if (!ok) break;
            chk("alt_spacing", cyc - tp, (k == 0) ? 3 : 3);
            tp = cyc;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Vector table: single-port accesses
        for (int v = 0; v < 9; v++)
            access(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp);

        // Reset during the ACCESS cycle of a p0 write
        @(negedge clk);
        t0 = wr_cnt;
        drive(0, 1'b1, 1'b1, 14'h0010, 16'h1234);
        @(negedge clk);
        chk("mid_access_we", {31'd0, dram_write_ena}, 1);
        chk("mid_access_addr", {18'd0, dram_addr}, 32'h10);
        reset = 1'b1;
        #1;
        chk("mid_reset_gates_we", {31'd0, dram_write_ena}, 0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        chk("mid_rst_acks", {30'd0, p1_ack, p0_ack}, 0);
        chk("mid_rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("mid_rst_dram_addr", {18'd0, dram_addr}, 0);
        chk("mid_rst_dram_data_in", {16'd0, dram_data_in}, 0);
        chk("mid_rst_no_write", wr_cnt - t0, 0);
        chk("mid_rst_mem_kept", {16'd0, mem[16'h0010]}, 32'hBEEF);
        reset = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (4) @(negedge clk);
        access(0, 1'b0, 14'h0010, '0, 16'hBEEF);

        // Read then idle: rdata holds, no write strobes
        access(0, 1'b0, 14'h0000, '0, 16'h5A5A);
        t0 = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_p0_rdata", {16'd0, p0_rdata}, 32'h5A5A);
            chk("idle_write_ena", {31'd0, dram_write_ena}, 0);
        end
        chk("idle_no_writes", wr_cnt - t0, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
